// File: rtl/wave_nco_pkg.sv
// Shared types and constants for the multi-channel waveform NCO.
// Mode encoding matches the cfg_mode port values.
package wave_nco_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_ZERO   = 2'd1,
      MODE_SQUARE = 2'd2,
      MODE_SAW    = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude table with a registered read port.
// Holds 2^AW+1 entries so that both 0 and pi/2 are represented exactly.
module quarter_sine_rom #(
   parameter int AW = 6,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic [AW:0]   address,
   output logic [DW-1:0] magnitude
);

   localparam int  DEPTH = (1 << AW) + 1;
   localparam real PI    = 3.14159265358979323846;

   // Contents are evaluated at elaboration: round(AMP * sin(pi*i / 2^(AW+1))).
   function automatic logic [DW-1:0] sine_mag(input int i);
      real amp;
      real a;
      amp = real'((1 << DW) - 1);
      a   = amp * $sin(PI * real'(i) / (2.0 * real'(1 << AW)));
      return DW'($rtoi(a + 0.5));
   endfunction

   logic [DW-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam logic [DW-1:0] VAL = sine_mag(i);
      assign rom[i] = VAL;
   end

   always_ff @(posedge clk) begin
      magnitude <= rom[address];
   end

endmodule

// File: rtl/wave_nco.sv
// Multi-channel NCO: per-channel accumulators advance together on a tick,
// then one shared quarter-wave table is visited channel by channel.
module wave_nco
   import wave_nco_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int PHASE_W  = 24,
   parameter int ADDR_W   = 8,
   parameter int OUT_W    = 16,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               tick,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [PHASE_W-1:0] cfg_freq,
   input  logic [1:0]         cfg_mode,
   input  logic               cfg_phase_rst,
   input  logic               overrun_clr,
   output logic               busy,
   output logic               overrun,
   output logic               sample_valid,
   output logic [CH_W-1:0]    sample_ch,
   output logic [OUT_W-1:0]   sample
);

   localparam int QW = ADDR_W - 2;
   localparam logic [QW:0]       QUARTER  = {1'b1, {QW{1'b0}}};
   localparam logic [ADDR_W-1:0] ZERO_OFS = {2'b11, {QW{1'b0}}};
   localparam logic [OUT_W-1:0]  MID      = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]  FULL     = '1;

   logic [PHASE_W-1:0] phase [CHANNELS];
   logic [PHASE_W-1:0] freq  [CHANNELS];
   mode_t              mode  [CHANNELS];

   state_t          state;
   logic [CH_W-1:0] k;
   logic [1:0]      drain_cnt;

   logic accept;
   logic cfg_hit;

   assign accept  = tick && en && (state == ST_IDLE);
   assign cfg_hit = cfg_we && (int'(cfg_ch) < CHANNELS);
   assign busy    = (state != ST_IDLE);

   // A phase reset is assigned last so it overrides a coincident advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            phase[i] <= '0;
            freq[i]  <= '0;
            mode[i]  <= MODE_SINE;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (accept) phase[i] <= phase[i] + freq[i];
            if (cfg_hit && int'(cfg_ch) == i) begin
               freq[i] <= cfg_freq;
               mode[i] <= mode_t'(cfg_mode);
               if (cfg_phase_rst) phase[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         k         <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_RUN;
                  k     <= '0;
               end
            end
            ST_RUN: begin
               if (k == CH_W'(CHANNELS - 1)) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state <= ST_IDLE;
               else drain_cnt <= drain_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Zero-start mode is sine shifted by three quarters, i.e. 1-cos.
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] eff_idx;
   logic [1:0]        quad;
   logic [QW:0]       rom_addr;
   logic [OUT_W-1:0]  saw_val;

   assign idx      = phase[k][PHASE_W-1 -: ADDR_W];
   assign eff_idx  = (mode[k] == MODE_ZERO) ? idx + ZERO_OFS : idx;
   assign quad     = eff_idx[ADDR_W-1 -: 2];
   assign rom_addr = quad[0] ? QUARTER - {1'b0, eff_idx[QW-1:0]} : {1'b0, eff_idx[QW-1:0]};

   if (PHASE_W >= OUT_W) begin : g_saw_wide
      assign saw_val = phase[k][PHASE_W-1 -: OUT_W];
   end else begin : g_saw_narrow
      assign saw_val = {{(OUT_W-PHASE_W){1'b0}}, phase[k]};
   end

   logic [OUT_W-2:0] rom_mag;

   quarter_sine_rom #(.AW(QW), .DW(OUT_W-1)) u_rom (
      .clk       (clk),
      .address   (rom_addr),
      .magnitude (rom_mag)
   );

   logic             s1_valid;
   logic [CH_W-1:0]  s1_ch;
   mode_t            s1_mode;
   logic             s1_neg;
   logic             s1_msb;
   logic [OUT_W-1:0] s1_saw;

   // Stage 1 runs alongside the table read so every mode sees equal latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_mode  <= MODE_SINE;
         s1_neg   <= 1'b0;
         s1_msb   <= 1'b0;
         s1_saw   <= '0;
      end else begin
         s1_valid <= (state == ST_RUN);
         if (state == ST_RUN) begin
            s1_ch   <= k;
            s1_mode <= mode[k];
            s1_neg  <= quad[1];
            s1_msb  <= phase[k][PHASE_W-1];
            s1_saw  <= saw_val;
         end
      end
   end

   logic [OUT_W-1:0] mag_ext;
   assign mag_ext = {1'b0, rom_mag};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample       <= '0;
      end else begin
         sample_valid <= s1_valid;
         if (s1_valid) begin
            sample_ch <= s1_ch;
            case (s1_mode)
               MODE_SINE, MODE_ZERO: sample <= s1_neg ? MID - mag_ext : MID + mag_ext;
               MODE_SQUARE:          sample <= s1_msb ? '0 : FULL;
               default:              sample <= s1_saw;
            endcase
         end
      end
   end

   // A set in the same cycle as a clear keeps the flag raised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= 1'b0;
      else if (tick && en && state != ST_IDLE) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

endmodule

// File: tb/tb_wave_nco.sv
// Scoreboard bench for wave_nco: a reference model predicts every sample,
// a monitor pops predictions as samples appear.
module tb_wave_nco;

   localparam int CHANNELS = 4;
   localparam int PHASE_W  = 24;
   localparam int ADDR_W   = 8;
   localparam int OUT_W    = 16;
   localparam int CH_W     = 2;
   localparam real PI      = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               tick = 1'b0;
   logic               cfg_we = 1'b0;
   logic [CH_W-1:0]    cfg_ch = '0;
   logic [PHASE_W-1:0] cfg_freq = '0;
   logic [1:0]         cfg_mode = '0;
   logic               cfg_phase_rst = 1'b0;
   logic               overrun_clr = 1'b0;
   logic               busy;
   logic               overrun;
   logic               sample_valid;
   logic [CH_W-1:0]    sample_ch;
   logic [OUT_W-1:0]   sample;

   wave_nco #(.CHANNELS(CHANNELS), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .tick(tick),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_mode(cfg_mode),
      .cfg_phase_rst(cfg_phase_rst), .overrun_clr(overrun_clr),
      .busy(busy), .overrun(overrun), .sample_valid(sample_valid),
      .sample_ch(sample_ch), .sample(sample)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int value;
   } exp_t;

   exp_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     valid_count = 0;
   int     last_sample [CHANNELS];
   longint m_phase [CHANNELS];
   longint m_freq  [CHANNELS];
   int     m_mode  [CHANNELS];

   // Direct evaluation of the waveform definitions, no quarter-wave folding.
   function automatic int model_sample(input longint ph, input int md);
      int  idx;
      int  mag;
      real s;
      idx = int'((ph >> (PHASE_W - ADDR_W)) & ((64'd1 << ADDR_W) - 1));
      case (md)
         0, 1: begin
            if (md == 1) idx = (idx + 3 * (1 << (ADDR_W - 2))) % (1 << ADDR_W);
            s   = real'((1 << (OUT_W - 1)) - 1) * $sin(2.0 * PI * real'(idx) / real'(1 << ADDR_W));
            mag = $rtoi(((s < 0.0) ? -s : s) + 0.5);
            return (s < 0.0) ? (1 << (OUT_W - 1)) - mag : (1 << (OUT_W - 1)) + mag;
         end
         2:       return (((ph >> (PHASE_W - 1)) & 1) != 0) ? 0 : (1 << OUT_W) - 1;
         default: return int'(ph >> (PHASE_W - OUT_W));
      endcase
   endfunction

   task automatic model_tick(input int rst_ch);
      for (int i = 0; i < CHANNELS; i++) begin
         m_phase[i] = (m_phase[i] + m_freq[i]) & ((64'd1 << PHASE_W) - 1);
         if (i == rst_ch) m_phase[i] = 0;
         exp_q.push_back('{i, model_sample(m_phase[i], m_mode[i])});
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sample_valid) begin
         valid_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_sample: got ch=%0d sample=%0d, required no sample", sample_ch, sample);
         end else begin
            e = exp_q.pop_front();
            if (sample_ch !== CH_W'(e.ch) || sample !== OUT_W'(e.value)) begin
               errors++;
               $display("[TB] FAIL scoreboard_sample: got ch=%0d sample=%0d, required ch=%0d sample=%0d",
                        sample_ch, sample, e.ch, e.value);
            end
         end
         last_sample[sample_ch] = int'(sample);
      end
   end

   task automatic cfg_write(input int ch, input longint f, input int md, input bit prst);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_freq = PHASE_W'(f);
      cfg_mode = 2'(md); cfg_phase_rst = prst;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_phase_rst = 1'b0;
      m_freq[ch] = f; m_mode[ch] = md;
      if (prst) m_phase[ch] = 0;
   endtask

   task automatic do_tick();
      @(posedge clk); #1;
      tick = 1'b1; en = 1'b1;
      model_tick(-1);
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic wait_round(input string name);
      for (int n = 0; n < 40 && (busy || exp_q.size() != 0); n++) @(negedge clk);
      checks++;
      if (busy || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_round_timeout: got busy=%0b pending=%0d, required busy=0 pending=0",
                  name, busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b0 || sample_valid !== 1'b0 || sample !== '0 || sample_ch !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%0b ovr=%0b valid=%0b ch=%0d sample=%0d, required all 0",
                  busy, overrun, sample_valid, sample_ch, sample);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid_count != 0) begin
         errors++;
         $display("[TB] FAIL reset_idle: got busy=%0b valids=%0d, required busy=0 valids=0", busy, valid_count);
      end
   endtask

   task automatic test_basic();
      int base;
      cfg_write(0, 64'd1 << 16, 0, 1'b1);
      base = valid_count;
      @(posedge clk); #1;
      tick = 1'b1; en = 1'b1;
      model_tick(-1);
      @(posedge clk); #1 tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_early_valid: got valid=%0b one cycle after E1, required 0", sample_valid);
      end
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b1 || sample_ch !== 2'd0 || sample !== 16'd33572) begin
         errors++;
         $display("[TB] FAIL basic_first_sample: got valid=%0b ch=%0d sample=%0d, required 1 0 33572",
                  sample_valid, sample_ch, sample);
      end
      wait_round("basic");
      for (int c = 1; c < CHANNELS; c++) begin
         checks++;
         if (last_sample[c] != 32768) begin
            errors++;
            $display("[TB] FAIL basic_idle_ch%0d: got %0d, required 32768", c, last_sample[c]);
         end
      end
      checks++;
      if (valid_count - base != CHANNELS) begin
         errors++;
         $display("[TB] FAIL basic_valid_count: got %0d, required %0d", valid_count - base, CHANNELS);
      end
   endtask

   task automatic test_waveforms();
      int zs [4] = '{32768, 65535, 32768, 1};
      int sq [4] = '{65535, 0, 0, 65535};
      int sw [4] = '{16384, 32768, 49152, 0};
      cfg_write(1, 64'd1 << 22, 1, 1'b1);
      cfg_write(2, 64'd1 << 22, 2, 1'b1);
      cfg_write(3, 64'd1 << 22, 3, 1'b1);
      for (int r = 0; r < 4; r++) begin
         do_tick();
         wait_round("waveforms");
         checks++;
         if (last_sample[1] != zs[r] || last_sample[2] != sq[r] || last_sample[3] != sw[r]) begin
            errors++;
            $display("[TB] FAIL waveforms_round%0d: got zero=%0d sq=%0d saw=%0d, required %0d %0d %0d",
                     r, last_sample[1], last_sample[2], last_sample[3], zs[r], sq[r], sw[r]);
         end
      end
   endtask

   task automatic test_wrap();
      cfg_write(0, 64'hFFFFFF, 3, 1'b1);
      for (int r = 0; r < 2; r++) begin
         do_tick();
         wait_round("wrap");
         checks++;
         if (last_sample[0] != 65535) begin
            errors++;
            $display("[TB] FAIL wrap_saw%0d: got %0d, required 65535", r, last_sample[0]);
         end
      end
      @(posedge clk); #1;
      tick = 1'b1; en = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_freq = 24'hFFFFFF; cfg_mode = 2'd3; cfg_phase_rst = 1'b1;
      model_tick(0);
      @(posedge clk); #1;
      tick = 1'b0; cfg_we = 1'b0; cfg_phase_rst = 1'b0;
      wait_round("phase_rst");
      checks++;
      if (last_sample[0] != 0) begin
         errors++;
         $display("[TB] FAIL phase_rst_on_tick: got %0d, required 0", last_sample[0]);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = valid_count;
      @(posedge clk); #1;
      tick = 1'b1; en = 1'b1;
      model_tick(-1);
      @(posedge clk); #1;
      @(posedge clk); #1 tick = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_set: got %0b, required 1", overrun);
      end
      wait_round("back_to_back");
      checks++;
      if (valid_count - base != CHANNELS || overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_round: got valids=%0d ovr=%0b, required %0d 1", valid_count - base, overrun, CHANNELS);
      end
      @(posedge clk); #1 overrun_clr = 1'b1;
      @(posedge clk); #1 overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overrun_clear: got %0b, required 0", overrun);
      end
      @(posedge clk); #1 tick = 1'b1;
      model_tick(-1);
      @(posedge clk); #1 overrun_clr = 1'b1;
      @(posedge clk); #1 tick = 1'b0; overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_set_beats_clear: got %0b, required 1", overrun);
      end
      wait_round("set_clear");
      @(posedge clk); #1 overrun_clr = 1'b1;
      @(posedge clk); #1 overrun_clr = 1'b0;
      base = valid_count;
      en = 1'b0; tick = 1'b1;
      repeat (3) @(posedge clk);
      #1 tick = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b0 || valid_count != base) begin
         errors++;
         $display("[TB] FAIL en_low_tick: got busy=%0b ovr=%0b valids=%0d, required 0 0 0", busy, overrun, valid_count - base);
      end
      en = 1'b1;
   endtask

   task automatic test_reset_mid_round();
      int base;
      int seen;
      base = valid_count;
      do_tick();
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (sample_valid) seen = 1;
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (!seen || busy !== 1'b0 || overrun !== 1'b0 || sample_valid !== 1'b0 || sample !== '0 || sample_ch !== '0) begin
         errors++;
         $display("[TB] FAIL mid_round_reset: got seen=%0d busy=%0b ovr=%0b valid=%0b ch=%0d sample=%0d, required 1 then all 0",
                  seen, busy, overrun, sample_valid, sample_ch, sample);
      end
      exp_q.delete();
      for (int i = 0; i < CHANNELS; i++) begin
         m_phase[i] = 0; m_freq[i] = 0; m_mode[i] = 0;
      end
      repeat (4) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (valid_count != base + 1) begin
         errors++;
         $display("[TB] FAIL reset_abort: got %0d valids, required %0d", valid_count - base, 1);
      end
      cfg_write(0, 64'd1 << 16, 0, 1'b0);
      do_tick();
      wait_round("after_reset");
      checks++;
      if (last_sample[0] != 33572 || last_sample[1] != 32768) begin
         errors++;
         $display("[TB] FAIL after_reset_round: got ch0=%0d ch1=%0d, required 33572 32768", last_sample[0], last_sample[1]);
      end
   endtask

   initial begin
      for (int i = 0; i < CHANNELS; i++) begin
         m_phase[i] = 0; m_freq[i] = 0; m_mode[i] = 0; last_sample[i] = -1;
      end
      test_reset();
      test_basic();
      test_waveforms();
      test_wrap();
      test_back_to_back();
      test_reset_mid_round();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/wave_nco.md
Name: wave_nco

Overview:
- Multi-channel numerically controlled waveform generator; successor to the fixed 256-entry single-channel waveform table.
- Each channel has its own phase accumulator, frequency word and waveform mode.
- On every sample tick, all channels advance in parallel, then share one quarter-wave table, time-multiplexed.
- Emits one sample per clock with channel tag. Feeds the PWM/DAC output stage.

Parameters:
CHANNELS, 4, number of channels (>=1)
PHASE_W, 24, phase accumulator / frequency word width
ADDR_W, 8, log2 of full-cycle table resolution (>=3); quarter table holds 2^(ADDR_W-2)+1 entries
OUT_W, 16, unsigned offset-binary sample width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  tick qualifier; tick ignored when low
tick  in  1  start one sample round
cfg_we  in  1  channel configuration write strobe
cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel
cfg_freq  in  PHASE_W  phase increment per tick
cfg_mode  in  2  0 sine, 1 zero-start (1-cos), 2 square, 3 sawtooth
cfg_phase_rst  in  1  with cfg_we: clear that channel's accumulator
overrun_clr  in  1  clear overrun flag
busy  out  1  round in progress (state != IDLE)
overrun  out  1  sticky: tick arrived while busy and en=1
sample_valid  out  1  sample/sample_ch valid this cycle
sample_ch  out  $clog2(CHANNELS) (min 1)  channel of sample
sample  out  OUT_W  waveform value

Behaviour:
- Reset (async): all phases, freqs, sample, sample_ch, sample_valid, busy, overrun = 0; modes = 0; FSM = IDLE. Reset mid-round aborts the round; no further sample_valid.
- MID = 2^(OUT_W-1); AMP = 2^(OUT_W-1)-1.
- Table: M[i] = round(AMP*sin(2*pi*i/2^ADDR_W)), i = 0..Q, Q = 2^(ADDR_W-2).
- Table read has 1-cycle registered latency.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, tick&en at edge E0: every accumulator += its freq, mod 2^PHASE_W. Go to RUN, k = 0.
- RUN: cycle after edge Ek looks up channel k.
  - Phase used is the post-advance value.
  - idx = phase[PHASE_W-1 -: ADDR_W].
  - k = CHANNELS-1 -> go to DRAIN.
- DRAIN: 2 cycles, then IDLE.
- Latency: channel k sample valid in the cycle after edge E(k+2). Exactly CHANNELS consecutive valid cycles per round, channels in ascending order.
- sine: quadrant q = idx[ADDR_W-1:ADDR_W-2], l = low bits.
  - q0 -> MID+M[l]
  - q1 -> MID+M[Q-l]
  - q2 -> MID-M[l]
  - q3 -> MID-M[Q-l]
  - Range 1..2^OUT_W-1.
- zero-start: sine evaluated at idx + 3*Q (mod 2^ADDR_W). idx 0 -> 1; idx 2Q -> 2^OUT_W-1.
- square: phase MSB 0 -> 2^OUT_W-1, else 0.
- sawtooth: phase top OUT_W bits (zero-extended if PHASE_W<OUT_W).
- Square and sawtooth bypass the table but are delayed to identical latency.
- Mode and phase are sampled at the channel's RUN cycle and carried down the pipeline.
- cfg write takes effect at the edge.
  - A write in the same cycle as that channel's lookup: old mode/phase used.
  - New freq is used from the next tick.
  - cfg_ch >= CHANNELS ignored.
- cfg_phase_rst coinciding with the tick-accept edge: reset wins, accumulator = 0.
- tick&en while busy: tick dropped, overrun <= 1.
  - overrun_clr clears it.
  - Simultaneous set and clear: set wins.
- en=0: tick ignored, no overrun; in-flight round completes.
- sample holds its last value when sample_valid=0.

Decomposition:
- Package wave_nco_pkg: mode enum (MODE_SINE, MODE_ZERO, MODE_SQUARE, MODE_SAW), FSM state enum, DRAIN_CYCLES=2.
- Sub-module quarter_sine_rom #(ADDR_W-2, OUT_W-1): clk, address, registered magnitude M. Contents generated at elaboration.
- Quadrant folding, mode mux and FSM stay in wave_nco.

Test Plan:
- Reset; ch0 sine, freq=2^16 (PHASE_W=24, ADDR_W=8); tick -> ch0 sample idx 1 = 32768+804 = 33572, valid 2 cycles after tick edge; ch1..3 freq 0 -> 32768.
- ch1 zero-start, freq=2^22; 4 ticks -> ch1 samples 32768, 65535, 32768, 1.
- ch2 square freq=2^22 -> 65535, 0, 0, 65535. ch3 saw freq=2^22 -> 16384, 32768, 49152, 0.
- ch0 saw, freq=0xFFFFFF from phase 0 -> 0xFFFF (wrap); next tick -> 0xFFFF (idx 255, phase top bits 0xFFFF); phase_rst on tick edge -> 0.
- Second tick 1 cycle after first -> dropped, overrun=1, exactly CHANNELS valids; overrun_clr -> 0; tick with en=0 -> nothing.
- Assert rst during RUN after 1 valid -> all outputs 0 immediately, no further valids; next tick runs a normal round from phase 0.
